// File: rtl/dsi_packet_scheduler.sv
// Frame/line timing scheduler for the DSI packet assembler: tracks line timing and
// issues one request at a time (VSS/HSS/RGB/CMD/BLANK), or releases the lanes to LP.
module dsi_packet_scheduler #(
  parameter int LINES_W = 12,
  parameter int CYC_W   = 16,
  parameter int GUARD   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               lpm_enable,
  input  logic [LINES_W-1:0] vsa_lines,
  input  logic [LINES_W-1:0] vbp_lines,
  input  logic [LINES_W-1:0] vact_lines,
  input  logic [LINES_W-1:0] vfp_lines,
  input  logic [CYC_W-1:0]   line_period,
  input  logic [15:0]        rgb_bytes,
  input  logic               cmd_pending,
  input  logic [15:0]        cmd_size,
  output logic               pkt_valid,
  output logic [2:0]         pkt_type,
  output logic [15:0]        pkt_size,
  input  logic               pkt_ready,
  input  logic               pkt_done,
  output logic               lp_allowed,
  output logic               frame_start,
  output logic               overrun,
  output logic               busy
);

  localparam int SUM_W = LINES_W + 2;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SYNC     = 3'd1;
  localparam logic [2:0] S_RGB      = 3'd2;
  localparam logic [2:0] S_CMD      = 3'd3;
  localparam logic [2:0] S_BLANK    = 3'd4;
  localparam logic [2:0] S_WAIT     = 3'd5;
  localparam logic [2:0] S_LINE_END = 3'd6;

  localparam logic [2:0] T_VSS   = 3'd0;
  localparam logic [2:0] T_HSS   = 3'd1;
  localparam logic [2:0] T_RGB   = 3'd2;
  localparam logic [2:0] T_CMD   = 3'd3;
  localparam logic [2:0] T_BLANK = 3'd4;

  localparam logic [CYC_W-1:0]   CYC_ONE  = CYC_W'(1);
  localparam logic [LINES_W-1:0] LINE_ONE = LINES_W'(1);
  localparam logic [SUM_W-1:0]   SUM_ONE  = SUM_W'(1);

  function automatic logic [15:0] sat_u16(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction

  logic [2:0]         state;
  logic [CYC_W-1:0]   line_cnt;
  logic [LINES_W-1:0] line_idx;
  logic               sync_pend;
  logic               stop_pend;

  logic [LINES_W-1:0] vsa_q, vbp_q, vact_q, vfp_q;
  logic [CYC_W-1:0]   period_q;

  logic [SUM_W-1:0] sum_vbp, sum_act, sum_total, idx_ext;
  logic             is_active, last_line, boundary, frame_load;
  logic [16:0]      cmd_words;
  logic             cmd_fit, blank_ok;
  logic [31:0]      blank_bytes;

  always_comb begin
    sum_vbp     = SUM_W'(vsa_q) + SUM_W'(vbp_q);
    sum_act     = sum_vbp + SUM_W'(vact_q);
    sum_total   = sum_act + SUM_W'(vfp_q);
    idx_ext     = SUM_W'(line_idx);
    is_active   = (idx_ext >= sum_vbp) && (idx_ext < sum_act);
    last_line   = (idx_ext == (sum_total - SUM_ONE));
    boundary    = (state != S_IDLE) && (line_cnt == '0);
    frame_load  = enable && (((state == S_IDLE)) || (boundary && last_line));
    cmd_words   = (17'(cmd_size) + 17'd3) >> 2;
    cmd_fit     = cmd_pending && ((32'(cmd_words) + 32'(GUARD)) <= 32'(line_cnt));
    // Test before subtracting so the guard margin never underflows.
    blank_ok    = !lpm_enable && (32'(line_cnt) >= (32'(GUARD) + 32'd3));
    blank_bytes = ((32'(line_cnt) - 32'(GUARD)) << 2) - 32'd6;
  end

  assign busy       = (state != S_IDLE);
  assign lp_allowed = (state == S_LINE_END) && lpm_enable && !pkt_valid;

  // Timing registers are captured only at frame start.
  always_ff @(posedge clk) begin
    if (frame_load) begin
      vsa_q    <= vsa_lines;
      vbp_q    <= vbp_lines;
      vact_q   <= vact_lines;
      vfp_q    <= vfp_lines;
      period_q <= line_period;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      line_cnt    <= '0;
      line_idx    <= '0;
      sync_pend   <= 1'b0;
      stop_pend   <= 1'b0;
      pkt_valid   <= 1'b0;
      pkt_type    <= 3'd0;
      pkt_size    <= 16'd0;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_start <= 1'b0;

      if (state != S_IDLE) begin
        if (boundary) begin
          line_cnt <= last_line ? (line_period - CYC_ONE) : (period_q - CYC_ONE);
          line_idx <= last_line ? '0 : (line_idx + LINE_ONE);
          if (last_line && enable) frame_start <= 1'b1;
        end else begin
          line_cnt <= line_cnt - CYC_ONE;
        end
      end

      case (state)
        S_IDLE: begin
          if (enable) begin
            frame_start <= 1'b1;
            line_idx    <= '0;
            line_cnt    <= line_period - CYC_ONE;
            sync_pend   <= 1'b0;
            stop_pend   <= 1'b0;
            state       <= S_SYNC;
          end
        end

        S_WAIT: begin
          if (pkt_valid && pkt_ready) pkt_valid <= 1'b0;
          if (pkt_done) begin
            // A line boundary seen now or while waiting forces the next sync.
            if (boundary || sync_pend) begin
              state     <= (stop_pend || (boundary && last_line && !enable)) ? S_IDLE : S_SYNC;
              sync_pend <= 1'b0;
              stop_pend <= 1'b0;
            end else begin
              case (pkt_type)
                T_VSS, T_HSS: state <= is_active ? S_RGB : S_CMD;
                T_BLANK:      state <= S_LINE_END;
                default:      state <= S_CMD;
              endcase
            end
          end else if (boundary) begin
            overrun   <= 1'b1;
            sync_pend <= 1'b1;
            if (last_line && !enable) stop_pend <= 1'b1;
          end
        end

        default: begin
          if (boundary) begin
            state <= (last_line && !enable) ? S_IDLE : S_SYNC;
          end else begin
            case (state)
              S_SYNC: begin
                pkt_valid <= 1'b1;
                pkt_type  <= (line_idx == '0) ? T_VSS : T_HSS;
                pkt_size  <= 16'd0;
                state     <= S_WAIT;
              end
              S_RGB: begin
                pkt_valid <= 1'b1;
                pkt_type  <= T_RGB;
                pkt_size  <= rgb_bytes;
                state     <= S_WAIT;
              end
              S_CMD: begin
                if (cmd_fit) begin
                  pkt_valid <= 1'b1;
                  pkt_type  <= T_CMD;
                  pkt_size  <= 16'd0;
                  state     <= S_WAIT;
                end else begin
                  state <= S_BLANK;
                end
              end
              S_BLANK: begin
                if (blank_ok) begin
                  pkt_valid <= 1'b1;
                  pkt_type  <= T_BLANK;
                  pkt_size  <= sat_u16(blank_bytes);
                  state     <= S_WAIT;
                end else begin
                  state <= S_LINE_END;
                end
              end
              default: state <= state;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_packet_scheduler.sv
// Directed bench for dsi_packet_scheduler: 1/1/2/1-line frames of 100 clocks,
// with a hand-timed assembler response so decisions land on chosen line_cnt values.
`timescale 1ns/1ps
module tb_dsi_packet_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, lpm_enable;
  logic [11:0] vsa_lines, vbp_lines, vact_lines, vfp_lines;
  logic [15:0] line_period, rgb_bytes, cmd_size;
  logic        cmd_pending;
  logic        pkt_valid;
  logic [2:0]  pkt_type;
  logic [15:0] pkt_size;
  logic        pkt_ready, pkt_done;
  logic        lp_allowed, frame_start, overrun, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fs_cnt = 0, fs_last = 0, fs_prev = 0;
  int fs_before, nreq, nvalid;

  dsi_packet_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lpm_enable(lpm_enable),
    .vsa_lines(vsa_lines), .vbp_lines(vbp_lines), .vact_lines(vact_lines),
    .vfp_lines(vfp_lines), .line_period(line_period), .rgb_bytes(rgb_bytes),
    .cmd_pending(cmd_pending), .cmd_size(cmd_size), .pkt_valid(pkt_valid),
    .pkt_type(pkt_type), .pkt_size(pkt_size), .pkt_ready(pkt_ready),
    .pkt_done(pkt_done), .lp_allowed(lp_allowed), .frame_start(frame_start),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_start) begin
      fs_prev <= fs_last;
      fs_last <= cyc;
      fs_cnt  <= fs_cnt + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_req(input string tag, input logic [2:0] t, input logic [15:0] s,
                            input int budget);
    int n = 0;
    while (pkt_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(pkt_valid), 32'd1);
    chk({tag, "_type"}, 32'(pkt_type), 32'(t));
    chk({tag, "_size"}, 32'(pkt_size), 32'(s));
    chk({tag, "_lp_low"}, 32'(lp_allowed), 32'd0);
  endtask

  task automatic done_after(input int d);
    repeat (d) tick();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
  endtask

  // Accept on the next edge, then pulse pkt_done d+1 edges later.
  task automatic finish(input int d);
    tick();
    done_after(d);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(pkt_valid), 32'd0);
    chk({tag, "_type"}, 32'(pkt_type), 32'd0);
    chk({tag, "_size"}, 32'(pkt_size), 32'd0);
    chk({tag, "_lp"}, 32'(lp_allowed), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; lpm_enable = 1'b1;
    vsa_lines = 12'd1; vbp_lines = 12'd1; vact_lines = 12'd2; vfp_lines = 12'd1;
    line_period = 16'd100; rgb_bytes = 16'd120;
    cmd_pending = 1'b0; cmd_size = 16'd0; pkt_ready = 1'b1; pkt_done = 1'b0;

    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Frame 1: VSS, HSS, HSS, RGB, HSS, RGB, HSS with LP after each line
    enable = 1'b1;
    tick();
    chk("f1_frame_start", 32'(frame_start), 32'd1);
    chk("f1_busy", 32'(busy), 32'd1);
    expect_req("f1_vss", 3'd0, 16'd0, 3);
    finish(2);
    repeat (3) tick();
    chk("f1_l0_lp", 32'(lp_allowed), 32'd1);
    expect_req("f1_l1_hss", 3'd1, 16'd0, 150);
    finish(2);
    repeat (3) tick();
    chk("f1_l1_lp", 32'(lp_allowed), 32'd1);
    for (int l = 2; l < 4; l++) begin
      expect_req($sformatf("f1_l%0d_hss", l), 3'd1, 16'd0, 150);
      finish(2);
      expect_req($sformatf("f1_l%0d_rgb", l), 3'd2, 16'd120, 3);
      finish(2);
      repeat (3) tick();
      chk($sformatf("f1_l%0d_lp", l), 32'(lp_allowed), 32'd1);
    end
    expect_req("f1_l4_hss", 3'd1, 16'd0, 150);
    finish(2);
    repeat (3) tick();
    chk("f1_l4_lp", 32'(lp_allowed), 32'd1);

    // Frame 2 line 0: blank decision at line_cnt=89 -> 4*85-6 = 334
    expect_req("f2_vss", 3'd0, 16'd0, 150);
    chk("f2_fs_count", 32'(fs_cnt), 32'd2);
    chk("f2_frame_period", 32'(fs_last - fs_prev), 32'd500);
    lpm_enable = 1'b0;
    finish(6);
    expect_req("f2_blank334", 3'd4, 16'd334, 3);
    finish(2);
    repeat (3) tick();
    chk("f2_l0_lp_off", 32'(lp_allowed), 32'd0);

    // Line 1: blank decision at line_cnt=6 -> no blank, quiet to line end
    expect_req("f2_l1_hss", 3'd1, 16'd0, 150);
    finish(89);
    nvalid = 0;
    repeat (6) begin
      tick();
      if (pkt_valid === 1'b1) nvalid++;
    end
    chk("f2_l1_no_blank", 32'(nvalid), 32'd0);

    // Line 2: 20-byte cmd (5 words) at line_cnt=8 does not fit
    lpm_enable = 1'b1; cmd_pending = 1'b1; cmd_size = 16'd20;
    expect_req("f2_l2_hss", 3'd1, 16'd0, 10);
    finish(2);
    expect_req("f2_l2_rgb", 3'd2, 16'd120, 3);
    finish(83);
    nvalid = 0;
    repeat (5) begin
      tick();
      if (pkt_valid === 1'b1) nvalid++;
    end
    chk("f2_l2_cmd_deferred", 32'(nvalid), 32'd0);
    chk("f2_l2_lp", 32'(lp_allowed), 32'd1);

    // Line 3: cmd at line_cnt=40 fits, then blank at line_cnt=34 -> 114
    lpm_enable = 1'b0;
    expect_req("f2_l3_hss", 3'd1, 16'd0, 20);
    finish(2);
    expect_req("f2_l3_rgb", 3'd2, 16'd120, 3);
    finish(51);
    expect_req("f2_l3_cmd", 3'd3, 16'd0, 3);
    cmd_pending = 1'b0;
    finish(2);
    expect_req("f2_l3_blank114", 3'd4, 16'd114, 4);
    finish(2);

    // Line 4: hold pkt_done across the boundary
    expect_req("f2_l4_hss", 3'd1, 16'd0, 150);
    chk("pre_overrun", 32'(overrun), 32'd0);
    tick();
    repeat (110) tick();
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("overrun_no_req", 32'(pkt_valid), 32'd0);
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    tick();
    chk("pend_sync_valid", 32'(pkt_valid), 32'd1);
    chk("pend_sync_type", 32'(pkt_type), 32'd0);
    lpm_enable = 1'b1;
    finish(2);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // pkt_ready low for 10 clocks: request held stable
    pkt_ready = 1'b0;
    expect_req("hold_hss", 3'd1, 16'd0, 150);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold_%0d", i), {28'd0, pkt_valid, pkt_type},
          {28'd0, 1'b1, 3'd1});
    end
    pkt_ready = 1'b1;
    tick();
    chk("hold_release", 32'(pkt_valid), 32'd0);
    done_after(2);

    // Reset mid-RGB, then restart
    expect_req("rst_hss", 3'd1, 16'd0, 150);
    finish(2);
    expect_req("rst_rgb", 3'd2, 16'd120, 3);
    tick();
    rst_n = 1'b0;
    tick();
    chk_all_zero("midreset");
    rst_n = 1'b1;
    tick();
    chk("restart_fs", 32'(frame_start), 32'd1);
    expect_req("restart_vss", 3'd0, 16'd0, 3);

    // enable dropped mid-frame: frame completes, then IDLE
    enable = 1'b0;
    fs_before = fs_cnt;
    finish(2);
    nreq = 0;
    for (int k = 0; k < 800 && busy === 1'b1; k++) begin
      tick();
      if (pkt_valid === 1'b1) begin
        nreq++;
        finish(2);
      end
    end
    chk("stop_idle", 32'(busy), 32'd0);
    chk("stop_reqs", 32'(nreq), 32'd6);
    chk("stop_no_fs", 32'(fs_cnt - fs_before), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
